// File: rtl/wavetable_pkg.sv
// -----------------------------------------------------------------------------
// wavetable_pkg
// Shared definitions for the wavetable sample memory, the NCO read path and the
// wavetable_writer frame loader.
//   SAMPLES_PER_WFM / SAMPLE_W / WFM_W / SAMPLE_ADDR_W : table geometry
//   SYNC_BYTE   : frame start marker on the loader byte stream
//   WFM_SLOTS   : number of waveform slots in the sample memory
//   CHECKSUM_EN : 1 when WAVETABLE_WRITER_CHECKSUM_EN is defined
//   wr_state_e  : loader FSM states
// -----------------------------------------------------------------------------
package wavetable_pkg;

  localparam int SAMPLES_PER_WFM = 64;
  localparam int SAMPLE_W        = 8;
  localparam int WFM_W           = 8;
  localparam int SAMPLE_ADDR_W   = 6;

  localparam logic [SAMPLE_W-1:0] SYNC_BYTE = 8'hA5;
  localparam int unsigned         WFM_SLOTS = 256;

`ifdef WAVETABLE_WRITER_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    COMMIT
  } wr_state_e;

  // True when a header byte names an existing waveform slot.
  function automatic logic wfm_in_range(input logic [WFM_W-1:0] wfm,
                                        input int unsigned      count);
    return 32'(wfm) < count;
  endfunction

endpackage

// File: rtl/wavetable_writer_if.sv
// -----------------------------------------------------------------------------
// wavetable_writer_if
// Byte stream into the wavetable loader (valid/ready, one byte per transfer).
//   in_data  : stream byte
//   in_valid : in_data valid, held by the producer until accepted
//   in_ready : consumer can accept; transfer on a rising clk edge with both high
// Modports: master = byte producer, slave = wavetable_writer.
// -----------------------------------------------------------------------------
interface wavetable_writer_if;
  import wavetable_pkg::*;

  logic [SAMPLE_W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/wavetable_frame_buffer.sv
// -----------------------------------------------------------------------------
// wavetable_frame_buffer
// Holds the 64 samples of the frame being received so nothing reaches the
// sample memory until the whole frame has been validated.
//   clk     : system clock
//   we      : write strobe (sample byte accepted in DATA)
//   wr_addr : sample index being written
//   wr_data : sample value
//   rd_addr : sample index read during COMMIT
//   rd_data : combinational read data
// -----------------------------------------------------------------------------
module wavetable_frame_buffer
  import wavetable_pkg::*;
(
  input  logic                     clk,
  input  logic                     we,
  input  logic [SAMPLE_ADDR_W-1:0] wr_addr,
  input  logic [SAMPLE_W-1:0]      wr_data,
  input  logic [SAMPLE_ADDR_W-1:0] rd_addr,
  output logic [SAMPLE_W-1:0]      rd_data
);

  logic [SAMPLE_W-1:0] mem [SAMPLES_PER_WFM];

  // NOTE: the array has no reset; every entry is rewritten in DATA before
  // COMMIT can read it, so stale contents are never observed.
  // NOTE: clocked state is always updated with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wavetable_writer.sv
// -----------------------------------------------------------------------------
// wavetable_writer
// Loads user waveforms into the wavetable sample memory from a framed byte
// stream: SYNC_BYTE, waveform number, 64 samples, optional checksum. The whole
// frame is buffered and only written to the sample memory once it is known to
// be good, so a corrupted or aborted frame never disturbs a playing waveform.
//
// Build option: WAVETABLE_WRITER_CHECKSUM_EN
//   defined   : 67-byte frames; the 8-bit sum of header + samples + checksum
//               must be zero or the frame is rejected.
//   undefined : 66-byte frames; COMMIT follows sample 63 directly and only an
//               out-of-range header is rejected.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   stream      : byte stream in (wavetable_writer_if.slave)
//   wr_en       : sample memory write strobe, 64 consecutive cycles per frame
//   wr_wfm      : waveform number being written
//   wr_sample   : sample index 0..63
//   wr_data     : sample value
//   busy        : FSM not in IDLE
//   frame_ok    : one-cycle pulse right after the last write of a frame
//   frame_err   : one-cycle pulse after a rejected frame's final byte
// Parameter
//   WFM_COUNT   : number of waveform slots; headers >= WFM_COUNT are rejected
// -----------------------------------------------------------------------------
module wavetable_writer
  import wavetable_pkg::*;
#(
  parameter int unsigned WFM_COUNT = WFM_SLOTS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  wavetable_writer_if.slave        stream,
  output logic                     wr_en,
  output logic [WFM_W-1:0]         wr_wfm,
  output logic [SAMPLE_ADDR_W-1:0] wr_sample,
  output logic [SAMPLE_W-1:0]      wr_data,
  output logic                     busy,
  output logic                     frame_ok,
  output logic                     frame_err
);

  localparam logic [SAMPLE_ADDR_W-1:0] LAST_SAMPLE = SAMPLE_ADDR_W'(SAMPLES_PER_WFM - 1);
  localparam logic [SAMPLE_ADDR_W-1:0] ADDR_ONE    = SAMPLE_ADDR_W'(1);

  wr_state_e                state_q, state_d;
  logic [SAMPLE_ADDR_W-1:0] cnt_q, cnt_d;
  logic [WFM_W-1:0]         wfm_q, wfm_d;

  logic                     wr_en_d;
  logic [WFM_W-1:0]         wr_wfm_d;
  logic [SAMPLE_ADDR_W-1:0] wr_sample_d;
  logic [SAMPLE_W-1:0]      wr_data_d;
  logic                     frame_ok_d;
  logic                     frame_err_d;

  logic                     in_ready;
  logic                     accept;
  logic                     start_commit;
  logic                     buf_we;
  logic [SAMPLE_ADDR_W-1:0] rd_addr;
  logic [SAMPLE_W-1:0]      rd_data;

`ifdef WAVETABLE_WRITER_CHECKSUM_EN
  logic [SAMPLE_W-1:0]      sum_q, sum_d;
  logic [SAMPLE_W-1:0]      sum_next;
  assign sum_next = sum_q + stream.in_data;
`endif

  // The only state that refuses bytes is COMMIT; the producer simply holds.
  assign in_ready        = (state_q != COMMIT);
  assign stream.in_ready = in_ready;
  assign accept          = stream.in_valid && in_ready;
  assign busy            = (state_q != IDLE);

  // Entering COMMIT preloads sample 0; inside COMMIT the read port runs one
  // index ahead of wr_sample so wr_data is registered alongside its index.
  assign rd_addr = (state_q == COMMIT) ? wr_sample + ADDR_ONE : '0;

  wavetable_frame_buffer u_frame_buffer (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (cnt_q),
    .wr_data (stream.in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here is defaulted first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    wfm_d        = wfm_q;
    wr_en_d      = 1'b0;
    wr_wfm_d     = '0;
    wr_sample_d  = '0;
    wr_data_d    = '0;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    start_commit = 1'b0;
    buf_we       = 1'b0;
`ifdef WAVETABLE_WRITER_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept && stream.in_data == SYNC_BYTE) begin
          state_d = HDR;
`ifdef WAVETABLE_WRITER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      HDR: begin
        if (accept) begin
          wfm_d = stream.in_data;
`ifdef WAVETABLE_WRITER_CHECKSUM_EN
          sum_d = sum_next;
`endif
          if (wfm_in_range(stream.in_data, WFM_COUNT)) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end
        end
      end

      // SYNC_BYTE values are ordinary samples here; there is no resync.
      DATA: begin
        if (accept) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + ADDR_ONE;
`ifdef WAVETABLE_WRITER_CHECKSUM_EN
          sum_d  = sum_next;
          if (cnt_q == LAST_SAMPLE) begin
            state_d = CSUM;
          end
`else
          if (cnt_q == LAST_SAMPLE) begin
            start_commit = 1'b1;
          end
`endif
        end
      end

`ifdef WAVETABLE_WRITER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          if (sum_next == '0) begin
            start_commit = 1'b1;
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end
        end
      end
`endif

      COMMIT: begin
        if (wr_sample == LAST_SAMPLE) begin
          state_d    = IDLE;
          frame_ok_d = 1'b1;
        end else begin
          wr_en_d     = 1'b1;
          wr_wfm_d    = wfm_q;
          wr_sample_d = rd_addr;
          wr_data_d   = rd_data;
        end
      end

      default: state_d = IDLE;
    endcase

    // The first write is registered on the same edge that accepts the final
    // byte, so wr_en rises in the very next cycle.
    if (start_commit) begin
      state_d     = COMMIT;
      wr_en_d     = 1'b1;
      wr_wfm_d    = wfm_q;
      wr_sample_d = '0;
      wr_data_d   = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wfm_q     <= '0;
      wr_en     <= 1'b0;
      wr_wfm    <= '0;
      wr_sample <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wfm_q     <= wfm_d;
      wr_en     <= wr_en_d;
      wr_wfm    <= wr_wfm_d;
      wr_sample <= wr_sample_d;
      wr_data   <= wr_data_d;
      frame_ok  <= frame_ok_d;
      frame_err <= frame_err_d;
    end
  end

`ifdef WAVETABLE_WRITER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

endmodule
